// File: rtl/cheat_code_loader_if.sv
// HPS menu download channel carrying the cheat file byte stream.
interface cheat_code_loader_if #(
  parameter int AW = 25
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;

  modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/cheat_code_loader.sv
// Parses a downloaded cheat file into 16-byte records, holds up to MAX_CODES codes
// and streams every slot to the code evaluator as one-cycle 38-bit packets.
module cheat_code_loader #(
  parameter int MAX_CODES = 9,
  parameter int AW        = 25
) (
  input  logic                clk,
  input  logic                reset,
  cheat_code_loader_if.slave  ioctl,
  input  logic                cheats_enable,
  output logic [37:0]         code,
  output logic [3:0]          code_count,
  output logic                busy,
  output logic                overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [3:0] LAST_IDX  = 4'(MAX_CODES - 1);
  localparam logic [3:0] FULL_CNT  = 4'(MAX_CODES);

  state_t        state_reg, state_next;
  logic [3:0]    idx_reg, idx_next;
  logic          dl_prev_reg;
  logic          en_copy_reg;
  logic [127:0]  staging_reg;
  logic          commit_reg;
  logic [3:0]    count_reg;
  logic          overflow_reg;
  logic [37:0]   code_reg, code_next;
  logic          clear_load, start_send;

  logic [MAX_CODES*33-1:0] slots_flat;
  logic [32:0]   slot_rd;

  logic          dl_rise, dl_fall, byte_we, slots_full, rec_valid, slot_we;
  logic [31:0]   rec_addr;
  logic [32:0]   rec_word;

  assign dl_rise = ioctl.ioctl_download & ~dl_prev_reg;
  assign dl_fall = ~ioctl.ioctl_download & dl_prev_reg;
  assign byte_we = (state_reg == LOAD) & ioctl.ioctl_download & ioctl.ioctl_wr;

  // Record layout: flags[31:0], addr[63:32], compare[95:64], replace[127:96]
  assign rec_addr   = staging_reg[63:32];
  assign rec_valid  = (rec_addr[31:16] == 16'd0) && rec_addr[15];
  assign rec_word   = {1'b1, staging_reg[0], rec_addr[14:0], staging_reg[71:64], staging_reg[103:96]};
  assign slots_full = (count_reg == FULL_CNT);
  assign slot_we    = commit_reg & rec_valid & ~slots_full & ~clear_load;

  for (genvar gi = 0; gi < MAX_CODES; gi++) begin : g_slot
    logic [32:0] slot_reg;
    always_ff @(posedge clk) begin
      if (reset || clear_load) begin
        slot_reg <= '0;
      end else if (slot_we && count_reg == 4'(gi)) begin
        slot_reg <= rec_word;
      end
    end
    assign slots_flat[gi*33 +: 33] = slot_reg;
  end

  always_comb begin
    slot_rd = '0;
    for (int k = 0; k < MAX_CODES; k++) begin
      if (idx_reg == 4'(k)) slot_rd = slots_flat[k*33 +: 33];
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    code_next  = '0;
    clear_load = 1'b0;
    start_send = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dl_rise) begin
          state_next = LOAD;
          clear_load = 1'b1;
        end else if (cheats_enable != en_copy_reg) begin
          state_next = SEND;
          idx_next   = 4'd0;
          start_send = 1'b1;
        end
      end
      LOAD: begin
        if (dl_fall) begin
          state_next = SEND;
          idx_next   = 4'd0;
          start_send = 1'b1;
        end
      end
      SEND: begin
        // A new download aborts the stream; the fresh load is re-sent in full afterwards.
        if (dl_rise) begin
          state_next = LOAD;
          clear_load = 1'b1;
        end else begin
          code_next = {1'b1, idx_reg, slot_rd[32] & cheats_enable, slot_rd[31:0]};
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = 4'd0;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 4'd0;
      code_reg     <= '0;
      dl_prev_reg  <= ioctl.ioctl_download;
      en_copy_reg  <= cheats_enable;
      staging_reg  <= '0;
      commit_reg   <= 1'b0;
      count_reg    <= 4'd0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      code_reg    <= code_next;
      dl_prev_reg <= ioctl.ioctl_download;
      if (start_send) en_copy_reg <= cheats_enable;
      if (clear_load) begin
        staging_reg  <= '0;
        commit_reg   <= 1'b0;
        count_reg    <= 4'd0;
        overflow_reg <= 1'b0;
      end else begin
        if (byte_we) staging_reg[{ioctl.ioctl_addr[3:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
        commit_reg <= byte_we && (ioctl.ioctl_addr[3:0] == 4'hF);
        if (commit_reg && rec_valid) begin
          if (slots_full) overflow_reg <= 1'b1;
          else            count_reg    <= count_reg + 4'd1;
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ioctl.ioctl_addr[AW-1:4], staging_reg[31:1], staging_reg[95:72], staging_reg[127:104]};

  assign code       = code_reg;
  assign code_count = count_reg;
  assign busy       = (state_reg != IDLE);
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_cheat_code_loader.sv
// Directed bench for cheat_code_loader: loads cheat files and checks the packet streams.
module tb_cheat_code_loader;
  localparam int MAXC = 9;
  localparam int AW   = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic        cheats_enable;
  logic [37:0] code;
  logic [3:0]  code_count;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [37:0] exp_pk [MAXC];

  cheat_code_loader_if #(.AW(AW)) ioctl ();

  cheat_code_loader #(.MAX_CODES(MAXC), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl         (ioctl.slave),
    .cheats_enable (cheats_enable),
    .code          (code),
    .code_count    (code_count),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [37:0] pk(input int i, input logic en, input logic cmpen,
                                     input logic [14:0] a, input logic [7:0] c, input logic [7:0] r);
    return {1'b1, 4'(i), en, cmpen, a, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp();
    for (int k = 0; k < MAXC; k++) exp_pk[k] = {1'b1, 4'(k), 33'd0};
  endtask

  task automatic put_byte(input int a, input logic [7:0] d);
    ioctl.ioctl_wr   = 1'b1;
    ioctl.ioctl_addr = AW'(a);
    ioctl.ioctl_dout = d;
    tick();
    ioctl.ioctl_wr   = 1'b0;
  endtask

  task automatic put_record(input int base, input logic [31:0] flags, input logic [31:0] addr,
                            input logic [31:0] cmp, input logic [31:0] rep);
    logic [127:0] r;
    r = {rep, cmp, addr, flags};
    for (int k = 0; k < 16; k++) put_byte(base + k, r[k*8 +: 8]);
    $display("record @%0d flags=%h addr=%h cmp=%h rep=%h", base, flags, addr, cmp, rep);
  endtask

  task automatic begin_dl();
    ioctl.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    tick();
    ioctl.ioctl_download = 1'b0;
  endtask

  task automatic expect_send(input string tag);
    int w;
    w = 0;
    while (!code[37] && w < 30) begin
      tick();
      w++;
    end
    check({tag, "_start"}, 64'(code[37]), 64'd1);
    for (int k = 0; k < MAXC; k++) begin
      check($sformatf("%s_pk%0d", tag, k), 64'(code), 64'(exp_pk[k]));
      tick();
    end
    check({tag, "_end_code"}, 64'(code), 64'd0);
    check({tag, "_end_busy"}, 64'(busy), 64'd0);
    $display("send %s done", tag);
  endtask

  initial begin
    int w;
    logic seen;
    reset = 1'b1;
    cheats_enable = 1'b1;
    ioctl.ioctl_download = 1'b0;
    ioctl.ioctl_wr = 1'b0;
    ioctl.ioctl_addr = '0;
    ioctl.ioctl_dout = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_code", 64'(code), 64'd0);
    check("rst_count", 64'(code_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    tick(); tick(); tick();
    check("rst_no_send", 64'(busy), 64'd0);

    // single record
    begin_dl();
    put_record(0, 32'h1, 32'h0000_C123, 32'h5A, 32'h99);
    end_dl();
    zero_exp();
    exp_pk[0] = pk(0, 1'b1, 1'b1, 15'h4123, 8'h5A, 8'h99);
    expect_send("t1");
    check("t1_count", 64'(code_count), 64'd1);
    check("t1_ovf", 64'(overflow), 64'd0);

    // two invalid records
    begin_dl();
    put_record(0, 32'h1, 32'h0000_4000, 32'h12, 32'h34);
    put_record(16, 32'h0, 32'h0001_8000, 32'h56, 32'h78);
    end_dl();
    zero_exp();
    expect_send("t2");
    check("t2_count", 64'(code_count), 64'd0);

    // overflow: ten valid records
    begin_dl();
    for (int r = 0; r < 10; r++)
      put_record(16 * r, 32'(r & 1), 32'h8000 + 32'(r * 16), 32'(r + 1), 32'hA0 + 32'(r));
    end_dl();
    for (int k = 0; k < MAXC; k++)
      exp_pk[k] = pk(k, 1'b1, 1'(k & 1), 15'(k * 16), 8'(k + 1), 8'(8'hA0 + k));
    expect_send("t3");
    check("t3_count", 64'(code_count), 64'd9);
    check("t3_ovf", 64'(overflow), 64'd1);

    // enable toggling
    begin_dl();
    put_record(0, 32'h1, 32'h0000_FFFF, 32'h11, 32'h22);
    put_record(16, 32'h0, 32'h0000_8001, 32'h33, 32'h44);
    end_dl();
    zero_exp();
    exp_pk[0] = pk(0, 1'b1, 1'b1, 15'h7FFF, 8'h11, 8'h22);
    exp_pk[1] = pk(1, 1'b1, 1'b0, 15'h0001, 8'h33, 8'h44);
    expect_send("t4a");
    check("t4_count", 64'(code_count), 64'd2);
    check("t4_ovf_cleared", 64'(overflow), 64'd0);
    cheats_enable = 1'b0;
    exp_pk[0] = pk(0, 1'b0, 1'b1, 15'h7FFF, 8'h11, 8'h22);
    exp_pk[1] = pk(1, 1'b0, 1'b0, 15'h0001, 8'h33, 8'h44);
    expect_send("t4b");
    cheats_enable = 1'b1;
    exp_pk[0] = pk(0, 1'b1, 1'b1, 15'h7FFF, 8'h11, 8'h22);
    exp_pk[1] = pk(1, 1'b1, 1'b0, 15'h0001, 8'h33, 8'h44);
    expect_send("t4c");

    // 20-byte file: trailing partial record discarded
    begin_dl();
    put_record(0, 32'h0, 32'h0000_9234, 32'h01, 32'h02);
    put_byte(16, 8'h01);
    put_byte(17, 8'h00);
    put_byte(18, 8'h00);
    put_byte(19, 8'h00);
    end_dl();
    zero_exp();
    exp_pk[0] = pk(0, 1'b1, 1'b0, 15'h1234, 8'h01, 8'h02);
    expect_send("t5");
    check("t5_count", 64'(code_count), 64'd1);

    // abort SEND at packet index 4
    begin_dl();
    put_record(0, 32'h1, 32'h0000_8ABC, 32'h55, 32'h66);
    end_dl();
    w = 0;
    while (!(code[37] && code[36:33] == 4'd4) && w < 30) begin
      tick();
      w++;
    end
    check("t6_pk4_seen", 64'(code), 64'(pk(4, 1'b0, 1'b0, 15'h0, 8'h0, 8'h0)));
    ioctl.ioctl_download = 1'b1;
    tick();
    check("t6_abort_code", 64'(code), 64'd0);
    check("t6_abort_busy", 64'(busy), 64'd1);
    put_record(0, 32'h0, 32'h0000_8010, 32'h77, 32'h88);
    end_dl();
    zero_exp();
    exp_pk[0] = pk(0, 1'b1, 1'b0, 15'h0010, 8'h77, 8'h88);
    expect_send("t6");

    // writes without download are ignored
    put_record(16, 32'h1, 32'h0000_8777, 32'hAA, 32'hBB);
    tick(); tick();
    check("t7_count", 64'(code_count), 64'd1);
    check("t7_busy", 64'(busy), 64'd0);

    // reset in the middle of a load
    begin_dl();
    put_byte(0, 8'h01);
    put_byte(1, 8'h00);
    check("t8_busy_load", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t8_code", 64'(code), 64'd0);
    check("t8_count", 64'(code_count), 64'd0);
    check("t8_busy", 64'(busy), 64'd0);
    check("t8_ovf", 64'(overflow), 64'd0);
    ioctl.ioctl_download = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (busy || code != 38'd0) seen = 1'b1;
    end
    check("t8_no_send", 64'(seen), 64'd0);

    // zero-byte download
    begin_dl();
    end_dl();
    zero_exp();
    expect_send("t9");
    check("t9_count", 64'(code_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
